// File: rtl/pt_frame_bridge.sv
// rtl/pt_frame_bridge.sv - byte stream to PT2262-style encoder bridge
// Assembles BYTES bytes into a payload, buffers one frame, and replays it REPEATS times.
module pt_frame_bridge #(
   parameter int BYTES          = 3,
   parameter int REPEATS        = 7,
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int MSB_FIRST      = 1,
   localparam int PW            = 8 * BYTES,
   localparam int IW            = $clog2(BYTES + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic [PW-1:0] enc_payload,
   output logic          enc_start,
   input  logic          enc_done,
   output logic          busy,
   output logic          overrun,
   output logic          timeout_err,
   output logic [IW-1:0] byte_idx
);

   localparam int RW = (REPEATS > 1) ? $clog2(REPEATS) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES);

   localparam logic [RW-1:0] REP_LAST = RW'(REPEATS - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(BYTES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [RW-1:0] rep_q, rep_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [PW-1:0] asm_q, asm_d;
   logic [PW-1:0] pend_q, pend_d;
   logic          pend_full_q, pend_full_d;
   logic [PW-1:0] pay_q, pay_d;
   logic          start_q, start_d;
   logic          ovr_q, ovr_d;
   logic          tmo_err_q, tmo_err_d;
   logic [PW-1:0] word;

   // Assembly register with the incoming byte merged into its lane.
   for (genvar k = 0; k < BYTES; k++) begin : g_lane
      localparam int SLOT = (MSB_FIRST != 0) ? BYTES - 1 - k : k;
      assign word[SLOT*8 +: 8] = (in_valid && idx_q == IW'(k)) ? in_data : asm_q[SLOT*8 +: 8];
   end

   always_comb begin
      state_d     = state_q;
      rep_d       = rep_q;
      gap_d       = gap_q;
      pay_d       = pay_q;
      start_d     = 1'b0;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      asm_d       = asm_q;
      idx_d       = idx_q;
      tmo_d       = tmo_q;
      ovr_d       = 1'b0;
      tmo_err_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (pend_full_q) begin
               pay_d       = pend_q;
               pend_full_d = 1'b0;
               rep_d       = '0;
               start_d     = 1'b1;
               state_d     = S_WAIT;
            end
         end
         S_WAIT: begin
            if (enc_done) begin
               if (rep_q == REP_LAST) begin
                  state_d = S_IDLE;
               end else begin
                  rep_d = rep_q + 1'b1;
                  if (GAP_CYCLES == 0) begin
                     start_d = 1'b1;
                  end else begin
                     gap_d   = '0;
                     state_d = S_GAP;
                  end
               end
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               start_d = 1'b1;
               state_d = S_WAIT;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // pend_full_d already reflects an IDLE hand-off this edge, so a frame landing now is kept.
      if (in_valid) begin
         tmo_d = '0;
         if (idx_q == IDX_LAST) begin
            idx_d = '0;
            asm_d = '0;
            if (pend_full_d) begin
               ovr_d = 1'b1;
            end else begin
               pend_d      = word;
               pend_full_d = 1'b1;
            end
         end else begin
            idx_d = idx_q + 1'b1;
            asm_d = word;
         end
      end else if (idx_q == '0) begin
         tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
         idx_d     = '0;
         asm_d     = '0;
         tmo_d     = '0;
         tmo_err_d = 1'b1;
      end else begin
         tmo_d = tmo_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rep_q       <= '0;
         gap_q       <= '0;
         tmo_q       <= '0;
         idx_q       <= '0;
         asm_q       <= '0;
         pend_q      <= '0;
         pend_full_q <= 1'b0;
         pay_q       <= '0;
         start_q     <= 1'b0;
         ovr_q       <= 1'b0;
         tmo_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rep_q       <= rep_d;
         gap_q       <= gap_d;
         tmo_q       <= tmo_d;
         idx_q       <= idx_d;
         asm_q       <= asm_d;
         pend_q      <= pend_d;
         pend_full_q <= pend_full_d;
         pay_q       <= pay_d;
         start_q     <= start_d;
         ovr_q       <= ovr_d;
         tmo_err_q   <= tmo_err_d;
      end
   end

   assign enc_payload = pay_q;
   assign enc_start   = start_q;
   assign overrun     = ovr_q;
   assign timeout_err = tmo_err_q;
   assign byte_idx    = idx_q;
   assign busy        = (state_q != S_IDLE) | pend_full_q;

endmodule

// File: tb/tb_pt_frame_bridge.sv
// tb/tb_pt_frame_bridge.sv - self-checking bench for pt_frame_bridge
// Three configurations share one byte stream: default, LSB-first, and single-shot with no gap.
module tb_pt_frame_bridge;

   localparam int NI  = 3;
   localparam int TMO = 50;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       enc_done [NI];
   logic       stray;

   logic [23:0] d_pay   [NI];
   logic        d_start [NI];
   logic        d_busy  [NI];
   logic        d_ovr   [NI];
   logic        d_tmo   [NI];
   logic [1:0]  d_idx   [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      pt_frame_bridge #(
         .BYTES(3),
         .REPEATS((g == 2) ? 1 : 7),
         .GAP_CYCLES((g == 2) ? 0 : 4),
         .TIMEOUT_CYCLES(TMO),
         .MSB_FIRST((g == 1) ? 0 : 1)
      ) u_dut (
         .clk(clk),
         .rst(rst),
         .in_valid(in_valid),
         .in_data(in_data),
         .enc_payload(d_pay[g]),
         .enc_start(d_start[g]),
         .enc_done(enc_done[g]),
         .busy(d_busy[g]),
         .overrun(d_ovr[g]),
         .timeout_err(d_tmo[g]),
         .byte_idx(d_idx[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int p_rep(int g);
      return (g == 2) ? 1 : 7;
   endfunction
   function automatic int p_gap(int g);
      return (g == 2) ? 0 : 4;
   endfunction
   function automatic bit p_msb(int g);
      return g != 1;
   endfunction

   // Behavioural model: bytes kept as a list, timeout measured as cycle distance,
   // sender described as "remaining starts" plus the cycle the next start is due.
   int          m_cyc = 0;
   bit          m_rst_seen;
   logic [7:0]  bb [NI][3];
   int          nb [NI];
   int          last_byte_cyc [NI];
   int          frame_cyc [NI];
   bit          pend_v [NI];
   logic [23:0] pend_w [NI];
   bit          act [NI];
   int          left [NI];
   int          start_at [NI];
   logic [23:0] cur [NI];
   bit          e_start [NI];
   bit          e_ovr [NI];
   bit          e_tmo [NI];

   always @(posedge clk) begin
      logic [23:0] w;
      m_cyc++;
      m_rst_seen = rst;
      for (int g = 0; g < NI; g++) begin
         e_start[g] = 1'b0;
         e_ovr[g]   = 1'b0;
         e_tmo[g]   = 1'b0;
         if (rst) begin
            nb[g]     = 0;
            pend_v[g] = 1'b0;
            pend_w[g] = '0;
            act[g]    = 1'b0;
            cur[g]    = '0;
         end else begin
            if (!act[g] && pend_v[g]) begin
               act[g]      = 1'b1;
               cur[g]      = pend_w[g];
               pend_v[g]   = 1'b0;
               left[g]     = p_rep(g);
               start_at[g] = m_cyc;
            end else if (act[g] && enc_done[g] && m_cyc > start_at[g]) begin
               left[g]--;
               if (left[g] == 0) act[g] = 1'b0;
               else start_at[g] = m_cyc + p_gap(g);
            end
            if (in_valid) begin
               bb[g][nb[g]]     = in_data;
               nb[g]++;
               last_byte_cyc[g] = m_cyc;
               if (nb[g] == 3) begin
                  w = '0;
                  for (int k = 0; k < 3; k++) begin
                     if (p_msb(g)) w = {w[15:0], bb[g][k]};
                     else w = w | (24'(bb[g][k]) << (8 * k));
                  end
                  nb[g]        = 0;
                  frame_cyc[g] = m_cyc;
                  if (pend_v[g]) e_ovr[g] = 1'b1;
                  else begin
                     pend_v[g] = 1'b1;
                     pend_w[g] = w;
                  end
               end
            end else if (nb[g] > 0 && m_cyc - last_byte_cyc[g] == TMO) begin
               nb[g]    = 0;
               e_tmo[g] = 1'b1;
            end
            e_start[g] = act[g] && (start_at[g] == m_cyc);
         end
      end
   end

   // Encoder stand-in: finishes each frame three cycles after seeing enc_start.
   int enc_cnt [NI];
   initial begin
      for (int g = 0; g < NI; g++) begin
         enc_done[g] = 1'b0;
         enc_cnt[g]  = 0;
      end
      forever begin
         @(negedge clk);
         for (int g = 0; g < NI; g++) begin
            enc_done[g] = stray;
            if (enc_cnt[g] > 0) begin
               enc_cnt[g]--;
               if (enc_cnt[g] == 0) enc_done[g] = 1'b1;
            end
            if (d_start[g]) enc_cnt[g] = 3;
         end
      end
   end

   int nvec = 0;
   int nerr = 0;
   int phase = 0;
   int prev_phase = 0;
   int n_st [NI];
   int n_ovr [NI];
   int n_tmo [NI];
   int first_lat [NI];
   logic [23:0] first_pay [NI];
   logic [23:0] last_pay [NI];

   task automatic chk(input string nm, input int g, input logic [31:0] act_v, input logic [31:0] exp_v);
      nvec++;
      if (act_v !== exp_v) begin
         nerr++;
         $display("FAIL %s inst%0d phase%0d cycle%0d: got 0x%0h, expected 0x%0h",
                  nm, g, prev_phase, m_cyc, act_v, exp_v);
      end
   endtask

   function automatic int exp_starts(int p, int g);
      case (p)
         1, 4, 6, 10: return (g == 2) ? 1 : 7;
         7:           return (g == 2) ? 3 : 14;
         8:           return (g == 2) ? 1 : 3;
         default:     return 0;
      endcase
   endfunction

   function automatic logic [23:0] exp_first(int p, int g);
      logic [23:0] msb_v;
      logic [23:0] lsb_v;
      case (p)
         1:       begin msb_v = 24'hA55A0F; lsb_v = 24'h0F5AA5; end
         4:       begin msb_v = 24'h334455; lsb_v = 24'h554433; end
         6:       begin msb_v = 24'h667788; lsb_v = 24'h887766; end
         default: begin msb_v = 24'hE1E2E3; lsb_v = 24'hE3E2E1; end
      endcase
      return (g == 1) ? lsb_v : msb_v;
   endfunction

   function automatic logic [23:0] exp_last7(int g);
      case (g)
         0:       return 24'h040506;
         1:       return 24'h060504;
         default: return 24'h070809;
      endcase
   endfunction

   task automatic end_checks(input int p);
      if (p >= 1 && p <= 10) begin
         for (int g = 0; g < NI; g++) begin
            chk("start_count", g, n_st[g], exp_starts(p, g));
            case (p)
               1, 4, 6, 10: begin
                  chk("first_payload", g, 32'(first_pay[g]), 32'(exp_first(p, g)));
                  chk("start_latency", g, first_lat[g], 1);
                  chk("overrun_count", g, n_ovr[g], 0);
                  chk("timeout_count", g, n_tmo[g], 0);
               end
               3: chk("timeout_count", g, n_tmo[g], 1);
               5: begin
                  chk("timeout_count", g, n_tmo[g], 0);
                  chk("byte_idx_late_byte", g, 32'(d_idx[g]), 2);
               end
               7: begin
                  chk("overrun_count", g, n_ovr[g], (g == 2) ? 0 : 1);
                  chk("last_payload", g, 32'(last_pay[g]), 32'(exp_last7(g)));
               end
               9: chk("busy_after_reset", g, 32'(d_busy[g]), 0);
               default: ;
            endcase
         end
      end
   endtask

   always @(negedge clk) begin
      if (m_cyc > 0) begin
         if (phase != prev_phase) begin
            end_checks(prev_phase);
            for (int g = 0; g < NI; g++) begin
               n_st[g]      = 0;
               n_ovr[g]     = 0;
               n_tmo[g]     = 0;
               first_lat[g] = -1;
               first_pay[g] = '0;
               last_pay[g]  = '0;
            end
            prev_phase = phase;
         end
         for (int g = 0; g < NI; g++) begin
            chk("enc_start", g, 32'(d_start[g]), 32'(e_start[g]));
            chk("enc_payload", g, 32'(d_pay[g]), 32'(cur[g]));
            chk("busy", g, 32'(d_busy[g]), 32'(act[g] | pend_v[g]));
            chk("overrun", g, 32'(d_ovr[g]), 32'(e_ovr[g]));
            chk("timeout_err", g, 32'(d_tmo[g]), 32'(e_tmo[g]));
            chk("byte_idx", g, 32'(d_idx[g]), nb[g]);
            if (m_rst_seen) begin
               chk("rst_enc_start", g, 32'(d_start[g]), 0);
               chk("rst_payload", g, 32'(d_pay[g]), 0);
               chk("rst_busy", g, 32'(d_busy[g]), 0);
               chk("rst_byte_idx", g, 32'(d_idx[g]), 0);
               chk("rst_overrun", g, 32'(d_ovr[g]), 0);
               chk("rst_timeout_err", g, 32'(d_tmo[g]), 0);
            end
            if (d_start[g]) begin
               if (n_st[g] == 0) begin
                  first_pay[g] = d_pay[g];
                  first_lat[g] = m_cyc - frame_cyc[g];
               end
               last_pay[g] = d_pay[g];
               n_st[g]++;
            end
            if (d_ovr[g]) n_ovr[g]++;
            if (d_tmo[g]) n_tmo[g]++;
         end
      end
   end

   // Caller sits at a negedge; the byte is sampled at the next posedge.
   task automatic send(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_phase(input int p);
      @(posedge clk);
      #1 phase = p;
      @(negedge clk);
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      stray    = 1'b0;
      idle(2);
      rst = 1'b0;

      set_phase(1);
      send(8'hA5); idle(19); send(8'h5A); idle(19); send(8'h0F);
      idle(100);

      set_phase(2);
      @(posedge clk); #1 stray = 1'b1;
      @(posedge clk); #1 stray = 1'b0;
      idle(10);

      set_phase(3);
      send(8'h11); idle(4); send(8'h22);
      idle(60);

      set_phase(4);
      send(8'h33); send(8'h44); send(8'h55);
      idle(100);

      set_phase(5);
      send(8'h66); idle(TMO - 1); send(8'h77);

      set_phase(6);
      send(8'h88);
      idle(100);

      set_phase(7);
      for (int i = 1; i <= 9; i++) send(8'(i));
      idle(160);

      set_phase(8);
      send(8'hA1); send(8'hB2); send(8'hC3);
      idle(16);
      send(8'hD4);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      set_phase(9);
      idle(30);

      set_phase(10);
      send(8'hE1); send(8'hE2); send(8'hE3);
      idle(100);

      set_phase(11);
      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
